pgm_sprite_linebuf: RTL and testbench
=====================================

PGM_SPRITE_LINEBUF -- requirements
Module: pgm_sprite_linebuf

Interface
REQ-001 The block SHALL have parameter LINE_W, default 448, meaning visible pixels per line.
REQ-002 The block SHALL have parameter PIX_BITS, default 5, meaning pixel colour-index bits; index 0 is transparent.
REQ-003 The block SHALL have parameter PAL_BITS, default 5, meaning sprite palette-select bits.
REQ-004 The block SHALL have parameter MAX_SPR, default 32, meaning sprite commands accepted per line.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset, with ports as follows:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
REQ-006 The block SHALL have the following ports:
- line_swap  in  1  single-cycle pulse at line end
- cmd_valid  in  1  sprite command valid
- cmd_ready  out  1  sprite command accepted
- cmd_x  in  11  signed start column
- cmd_len  in  10  pixel count, 1..1023
- cmd_pal  in  PAL_BITS  palette select
- cmd_flipx  in  1  draw right-to-left from cmd_x+cmd_len-1
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted
- pix_data  in  PIX_BITS  colour index
- rd_x  in  $clog2(LINE_W)  display read column
- rd_pix  out  PAL_BITS+PIX_BITS  {pal,index} of front buffer
- busy  out  1  clearing or drawing
- spr_count  out  6  commands accepted this line, saturating
- overflow  out  1  command count exceeded MAX_SPR this line
- swap_err  out  1  line_swap arrived while DRAW

Function
REQ-007 The block SHALL hold two LINE_W-entry buffers, front and back; display reads front, drawing writes back.
REQ-008 rd_pix SHALL equal front[rd_x] registered, one-cycle latency; rd_x >= LINE_W SHALL return 0.
REQ-009 The FSM SHALL have states CLEAR, IDLE and DRAW.
REQ-010 CLEAR SHALL write 0 to one back-buffer entry per cycle, addresses 0..LINE_W-1, then go to IDLE; it takes LINE_W cycles.
REQ-011 In IDLE, cmd_ready SHALL be 1 and the block SHALL accept on cmd_valid&cmd_ready, latch the command, and go to DRAW.
REQ-012 In DRAW, pix_ready SHALL be 1 and cmd_ready SHALL be 0; each pix_valid&pix_ready handshake SHALL consume one pixel; DRAW SHALL exit to IDLE after cmd_len pixels.
REQ-013 For pixel n (0-based), the column SHALL be cmd_x+n when cmd_flipx=0 and cmd_x+cmd_len-1-n when cmd_flipx=1, computed as a signed 12-bit value.
REQ-014 A pixel SHALL be written as {cmd_pal,pix_data} only if its column is in 0..LINE_W-1, pix_data != 0 and the back entry index field == 0, so that the earlier command wins.
REQ-015 Off-line or transparent pixels SHALL still be consumed, with no write.
REQ-016 spr_count SHALL increment per accepted command and saturate at 63.
REQ-017 Once MAX_SPR commands have been accepted, cmd_ready SHALL stay 0 for the rest of the line.
REQ-018 overflow SHALL set if cmd_valid is high in IDLE while spr_count==MAX_SPR.
REQ-019 On line_swap in IDLE, the block SHALL exchange front and back next cycle, clear spr_count and overflow, and enter CLEAR.
REQ-020 On line_swap in DRAW, the block SHALL abort the command (remaining pixels are not consumed by this block), swap, set swap_err (sticky until reset), and enter CLEAR.
REQ-021 On line_swap in CLEAR, the block SHALL swap, set swap_err, and restart CLEAR at address 0.
REQ-022 busy SHALL be 1 in CLEAR and DRAW.
REQ-023 pix_ready SHALL be 0 outside DRAW.
REQ-024 cmd_ready SHALL be 0 outside IDLE.
REQ-025 A write and a read of the same physical buffer SHALL never occur in the same cycle.

Reset
REQ-026 Reset SHALL force CLEAR at address 0 with buffer select 0, and SHALL set spr_count=0, overflow=0, swap_err=0, rd_pix=0, cmd_ready=0, pix_ready=0 and busy=1.
REQ-027 Front-buffer contents after reset are undefined until the first swap following a completed CLEAR.
REQ-028 Reset asserted mid-DRAW SHALL abandon the command with no further writes.

Verification
REQ-029 Reset, wait LINE_W cycles, swap, wait LINE_W cycles -> busy=0, cmd_ready=1; after a second swap, rd_pix=0 for all rd_x.
REQ-030 cmd x=10,len=4,pal=3, pixels 1,0,2,3, swap -> rd_x 10..13 = {3,1},0,{3,2},{3,3}.
REQ-031 Same command with flipx=1 -> rd_x 13,12,11,10 = {3,1},0,{3,2},{3,3}.
REQ-032 Cmd A x=-2,len=4,pix 5,5,5,5, then Cmd B x=0,len=2,pix 7,7 -> rd_x0,1 = A's value 5, and rd_x 2 = 0.
REQ-033 33 commands of len=1 with MAX_SPR=32 -> the 33rd is never accepted, overflow=1, spr_count=32.
REQ-034 line_swap after 2 of 8 pixels -> swap_err=1, busy=1 for LINE_W cycles, and the 2 written pixels are visible.

Source files
------------

// File: rtl/pgm_sprite_linebuf_if.sv
// Sprite command and pixel stream channels into the line buffer.
//   master : drives cmd_* / pix_valid / pix_data, observes the ready signals
//   slave  : the line buffer, returns cmd_ready / pix_ready
interface pgm_sprite_linebuf_if #(
  parameter int unsigned PIX_BITS = 5,
  parameter int unsigned PAL_BITS = 5
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [10:0]         cmd_x;
  logic [9:0]          cmd_len;
  logic [PAL_BITS-1:0] cmd_pal;
  logic                cmd_flipx;
  logic                pix_valid;
  logic                pix_ready;
  logic [PIX_BITS-1:0] pix_data;

  modport master (
    output cmd_valid, cmd_x, cmd_len, cmd_pal, cmd_flipx, pix_valid, pix_data,
    input  cmd_ready, pix_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_len, cmd_pal, cmd_flipx, pix_valid, pix_data,
    output cmd_ready, pix_ready
  );
endinterface

// File: rtl/pgm_sprite_linebuf.sv
// Double-buffered sprite line buffer. The back buffer is cleared, then sprite
// commands draw pixel runs into it (first opaque writer wins per column);
// line_swap exchanges front/back and the display reads the front buffer.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   line_swap         single-cycle line-end pulse
//   bus (slave)       sprite command channel + pixel stream channel
//   rd_x / rd_pix     display read column / registered {pal,index}
//   busy              clearing or drawing
//   spr_count         commands accepted this line (saturating)
//   overflow          command offered after MAX_SPR accepted this line
//   swap_err          sticky: line_swap arrived outside IDLE
module pgm_sprite_linebuf #(
  parameter int unsigned LINE_W   = 448,
  parameter int unsigned PIX_BITS = 5,
  parameter int unsigned PAL_BITS = 5,
  parameter int unsigned MAX_SPR  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         line_swap,
  pgm_sprite_linebuf_if.slave          bus,
  input  logic [$clog2(LINE_W)-1:0]    rd_x,
  output logic [PAL_BITS+PIX_BITS-1:0] rd_pix,
  output logic                         busy,
  output logic [5:0]                   spr_count,
  output logic                         overflow,
  output logic                         swap_err
);
  localparam int unsigned XW = $clog2(LINE_W);
  localparam int unsigned DW = PAL_BITS + PIX_BITS;
  localparam logic [XW-1:0] LAST_X  = XW'(LINE_W - 1);
  localparam logic [10:0]   LAST_XC = 11'(LINE_W - 1);
  localparam logic [5:0]    MAX_CNT = 6'(MAX_SPR);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAW} state_t;

  state_t              state, state_nxt;
  logic [XW-1:0]       clr_addr, clr_nxt;
  logic                buf_sel;
  logic [10:0]         cx;
  logic [9:0]          clen;
  logic [PAL_BITS-1:0] cpal;
  logic                cflip;
  logic [9:0]          pix_n, pix_n_nxt;
  logic                cmd_ready_q, pix_ready_q;
  logic                cmd_take, swap;
  logic                wr_en;
  logic [XW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic [11:0]         col;
  logic                col_ok;
  logic [XW-1:0]       col_addr;
  logic [DW-1:0]       back_word;
  logic [5:0]          spr_nxt;

  logic [DW-1:0] mem [2][LINE_W];

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.pix_ready = pix_ready_q;

  // Signed 12-bit column of the current pixel; flipped runs start at the far end.
  always_comb begin
    if (cflip) col = {cx[10], cx} + {2'b00, clen} - 12'd1 - {2'b00, pix_n};
    else       col = {cx[10], cx} + {2'b00, pix_n};
    col_ok   = !col[11] && (col[10:0] <= LAST_XC);
    col_addr = col_ok ? col[XW-1:0] : '0;
  end

  // Back-buffer entry under the current pixel, for the earlier-command-wins test.
  assign back_word = mem[~buf_sel][col_addr];

  // Next-state and datapath control; line_swap overrides everything.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_addr;
    pix_n_nxt = pix_n;
    cmd_take  = 1'b0;
    swap      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        if (clr_addr == LAST_X) begin
          clr_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          clr_nxt = clr_addr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_take  = 1'b1;
          pix_n_nxt = '0;
          state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (bus.pix_valid && pix_ready_q) begin
          if (col_ok && (bus.pix_data != '0) && (back_word[PIX_BITS-1:0] == '0)) begin
            wr_en   = 1'b1;
            wr_addr = col_addr;
            wr_data = {cpal, bus.pix_data};
          end
          if (pix_n == clen - 10'd1) state_nxt = ST_IDLE;
          else                       pix_n_nxt = pix_n + 10'd1;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
    if (line_swap) begin
      swap      = 1'b1;
      state_nxt = ST_CLEAR;
      clr_nxt   = '0;
      wr_en     = 1'b0;
      cmd_take  = 1'b0;
    end
    if (swap)                            spr_nxt = '0;
    else if (cmd_take && spr_count != 6'd63) spr_nxt = spr_count + 6'd1;
    else                                 spr_nxt = spr_count;
  end

  // State, command latch, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_CLEAR;
      clr_addr    <= '0;
      buf_sel     <= 1'b0;
      cx          <= '0;
      clen        <= '0;
      cpal        <= '0;
      cflip       <= 1'b0;
      pix_n       <= '0;
      spr_count   <= '0;
      overflow    <= 1'b0;
      swap_err    <= 1'b0;
      cmd_ready_q <= 1'b0;
      pix_ready_q <= 1'b0;
      busy        <= 1'b1;
      rd_pix      <= '0;
    end else begin
      state     <= state_nxt;
      clr_addr  <= clr_nxt;
      pix_n     <= pix_n_nxt;
      spr_count <= spr_nxt;
      if (swap) buf_sel <= ~buf_sel;
      if (cmd_take) begin
        cx    <= bus.cmd_x;
        clen  <= bus.cmd_len;
        cpal  <= bus.cmd_pal;
        cflip <= bus.cmd_flipx;
      end
      if (swap)
        overflow <= 1'b0;
      else if (state == ST_IDLE && bus.cmd_valid && spr_count == MAX_CNT)
        overflow <= 1'b1;
      if (swap && state != ST_IDLE) swap_err <= 1'b1;
      cmd_ready_q <= (state_nxt == ST_IDLE) && (spr_nxt < MAX_CNT);
      pix_ready_q <= (state_nxt == ST_DRAW);
      busy        <= (state_nxt != ST_IDLE);
      // Front read always targets the buffer the draw side is not writing.
      if (rd_x <= LAST_X) rd_pix <= mem[buf_sel][rd_x];
      else                rd_pix <= '0;
    end
  end

  // Back-buffer write port; nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[~buf_sel][wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_pgm_sprite_linebuf.sv
// Bench for pgm_sprite_linebuf: drives commands/pixels, keeps a behavioural
// model of both line buffers, queues expected read data and compares on output.
module tb_pgm_sprite_linebuf;
  localparam int LINE_W  = 448;
  localparam int MAX_SPR = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_swap;
  logic [8:0] rd_x;
  logic [9:0] rd_pix;
  logic       busy;
  logic [5:0] spr_count;
  logic       overflow;
  logic       swap_err;

  pgm_sprite_linebuf_if #(.PIX_BITS(5), .PAL_BITS(5)) bus ();

  pgm_sprite_linebuf #(
    .LINE_W(LINE_W), .PIX_BITS(5), .PAL_BITS(5), .MAX_SPR(MAX_SPR)
  ) dut (
    .clk(clk), .reset(reset), .line_swap(line_swap), .bus(bus),
    .rd_x(rd_x), .rd_pix(rd_pix), .busy(busy), .spr_count(spr_count),
    .overflow(overflow), .swap_err(swap_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int pq[$];
  int mdl[2][LINE_W];
  int msel = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void mdl_pix(int col, int pal, int pix);
    int b;
    b = msel ^ 1;
    if (col >= 0 && col < LINE_W && pix != 0 && (mdl[b][col] % 32) == 0)
      mdl[b][col] = pal * 32 + pix;
  endfunction

  function automatic void mdl_swap();
    msel = msel ^ 1;
    for (int i = 0; i < LINE_W; i++) mdl[msel ^ 1][i] = 0;
  endfunction

  task automatic send_cmd(input int x, input int len, input int pal, input bit flip,
                          input int budget, output bit ok);
    bit hs;
    bus.cmd_x     = 11'(x);
    bus.cmd_len   = 10'(len);
    bus.cmd_pal   = 5'(pal);
    bus.cmd_flipx = flip;
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      hs = bus.cmd_ready;
      tick();
      ok = hs;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_pix(input int p, output bit ok);
    bit hs;
    bus.pix_data  = 5'(p);
    bus.pix_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      hs = bus.pix_ready;
      tick();
      ok = hs;
    end
    bus.pix_valid = 1'b0;
  endtask

  // One full command: pixels taken from pq, model updated per consumed pixel.
  task automatic draw(input int x, input int len, input int pal, input bit flip);
    bit ok;
    bit pok;
    int col;
    send_cmd(x, len, pal, flip, 50, ok);
    chk("cmd_accept", 32'(ok), 1);
    for (int n = 0; n < len; n++) begin
      send_pix(pq[n], pok);
      chk("pix_accept", 32'(pok), 1);
      col = flip ? (x + len - 1 - n) : (x + n);
      mdl_pix(col, pal, pq[n]);
    end
  endtask

  task automatic wait_clear(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_swap();
    line_swap = 1'b1;
    tick();
    line_swap = 1'b0;
    mdl_swap();
  endtask

  task automatic swap_and_clear();
    int cyc;
    do_swap();
    wait_clear(cyc);
    chk("clear_len", 32'(cyc), LINE_W);
  endtask

  task automatic read_px(input int x, input int exp, input string tag);
    rd_x = 9'(x);
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else                   chk(tag, 32'(rd_pix), 32'(exp_q.pop_front()));
  endtask

  task automatic sweep();
    for (int x = 0; x < LINE_W; x++) read_px(x, mdl[msel][x], "sweep");
    read_px(LINE_W, 0, "rd_oob_448");
    read_px(511, 0, "rd_oob_511");
  endtask

  initial begin
    bit ok;
    int cyc;
    int len;
    int x;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LINE_W; i++) mdl[b][i] = 0;
    reset         = 1'b1;
    line_swap     = 1'b0;
    rd_x          = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_len   = '0;
    bus.cmd_pal   = '0;
    bus.cmd_flipx = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_pix_ready", 32'(bus.pix_ready), 0);
    chk("rst_spr_count", 32'(spr_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_swap_err", 32'(swap_err), 0);
    chk("rst_rd_pix", 32'(rd_pix), 0);
    reset = 1'b0;
    wait_clear(cyc);
    chk("clear_len_rst", 32'(cyc), LINE_W);

    // Bring-up: two swaps leave an all-zero front buffer.
    swap_and_clear();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("idle_pix_ready", 32'(bus.pix_ready), 0);
    swap_and_clear();
    sweep();

    // Plain run with a transparent pixel.
    pq = '{1, 0, 2, 3};
    draw(10, 4, 3, 1'b0);
    chk("spr_count_1", 32'(spr_count), 1);
    swap_and_clear();
    chk("swap_err_clean", 32'(swap_err), 0);
    chk("spr_count_swap", 32'(spr_count), 0);
    read_px(10, 97, "a_x10");
    read_px(11, 0,  "a_x11");
    read_px(12, 98, "a_x12");
    read_px(13, 99, "a_x13");
    sweep();

    // Flipped run, then overlapping runs clipped at the left edge.
    pq = '{1, 0, 2, 3};
    draw(10, 4, 3, 1'b1);
    pq = '{5, 5, 5, 5};
    draw(-2, 4, 1, 1'b0);
    pq = '{7, 7};
    draw(0, 2, 2, 1'b0);
    chk("spr_count_3", 32'(spr_count), 3);
    swap_and_clear();
    read_px(13, 97, "f_x13");
    read_px(12, 0,  "f_x12");
    read_px(11, 98, "f_x11");
    read_px(10, 99, "f_x10");
    read_px(0, 37, "ovl_x0");
    read_px(1, 37, "ovl_x1");
    read_px(2, 0,  "ovl_x2");
    sweep();

    // Command limit: the 33rd command is refused and flags overflow.
    for (int i = 0; i < MAX_SPR; i++) begin
      pq = '{(i % 31) + 1};
      draw(100 + i * 3, 1, i % 32, 1'b0);
    end
    chk("lim_spr_count", 32'(spr_count), MAX_SPR);
    chk("lim_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("lim_busy", 32'(busy), 0);
    send_cmd(50, 1, 1, 1'b0, 20, ok);
    chk("cmd33_accept", 32'(ok), 0);
    chk("lim_overflow", 32'(overflow), 1);
    chk("lim_spr_count2", 32'(spr_count), MAX_SPR);
    do_swap();
    chk("swap_overflow_clr", 32'(overflow), 0);
    chk("swap_spr_clr", 32'(spr_count), 0);
    wait_clear(cyc);
    chk("clear_len_lim", 32'(cyc), LINE_W);
    sweep();

    // Swap during DRAW after 2 of 8 pixels.
    send_cmd(200, 8, 4, 1'b0, 50, ok);
    chk("abort_cmd_accept", 32'(ok), 1);
    send_pix(6, ok);
    mdl_pix(200, 4, 6);
    send_pix(7, ok);
    mdl_pix(201, 4, 7);
    chk("abort_in_draw", 32'(bus.pix_ready), 1);
    do_swap();
    chk("abort_swap_err", 32'(swap_err), 1);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_pix_ready", 32'(bus.pix_ready), 0);
    wait_clear(cyc);
    chk("clear_len_abort", 32'(cyc), LINE_W);
    read_px(200, 134, "abort_x200");
    read_px(201, 135, "abort_x201");
    read_px(202, 0,   "abort_x202");
    sweep();

    // Random runs including flips and off-line columns.
    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(1, 40));
      x   = int'($urandom_range(0, 540)) - 50;
      pq.delete();
      for (int n = 0; n < len; n++)
        pq.push_back(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)));
      draw(x, len, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    swap_and_clear();
    chk("swap_err_sticky", 32'(swap_err), 1);
    sweep();

    // Reset in the middle of a command.
    send_cmd(300, 5, 2, 1'b0, 50, ok);
    send_pix(3, ok);
    reset = 1'b1;
    tick();
    chk("mid_rst_swap_err", 32'(swap_err), 0);
    chk("mid_rst_busy", 32'(busy), 1);
    chk("mid_rst_pix_ready", 32'(bus.pix_ready), 0);
    chk("mid_rst_rd_pix", 32'(rd_pix), 0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
